// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit control slice.
package uart_pkg;

   localparam int FRAME_BASE_BITS = 10;
   localparam int STOP_MAX        = 1;
   localparam int DIV_W_DEFAULT   = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_WAIT_DONE,
      ST_DONE
   } tx_state_e;

   // Any nonzero stop selection means two stop bits, reported to the datapath as 1.
   function automatic logic [1:0] clamp_stop(input logic [1:0] sel);
      return (sel != 2'd0) ? 2'(STOP_MAX) : 2'd0;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..div-1 while running and strobes on the terminal count.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             run,
   input  logic [DIV_W-1:0] div,
   output logic             strobe
);

   logic [DIV_W-1:0] cnt;

   assign strobe = run && (cnt == (div - DIV_W'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= strobe ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte, strobes the shift register once per
// bit period and cross-checks the datapath's frame-complete flag.
//
//   state        | meaning
//   -------------+-------------------------------------------------------------
//   ST_IDLE      | ready for a byte, line held idle-high
//   ST_LOAD      | one-cycle shift-register load pulse
//   ST_SHIFT     | line driven from shift register, one strobe per bit period
//   ST_WAIT_DONE | all strobes issued, waiting for the datapath's complete flag
//   ST_DONE      | one-cycle completion pulse
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_W        = DIV_W_DEFAULT,
   parameter int DONE_TIMEOUT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [7:0]       tx_data,
   input  logic [1:0]       cfg_stop,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             data_transmitted,
   output logic             load_en,
   output logic             tx_enable,
   output logic             tx_sel,
   output logic [7:0]       tx_byte,
   output logic [1:0]       stop_bit,
   output logic             busy,
   output logic             tx_done,
   output logic             err,
   input  logic             err_clr
);

   localparam int WT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

   tx_state_e        state;
   tx_state_e        state_nxt;
   logic [DIV_W-1:0] div_q;
   logic [3:0]       strobe_cnt;
   logic [3:0]       last_idx;
   logic [WT_W-1:0]  wait_cnt;
   logic             strobe;
   logic             baud_run;
   logic             baud_clear;
   logic             err_set;

   assign last_idx  = 4'(FRAME_BASE_BITS - 1) + {2'b00, stop_bit};
   assign tx_enable = strobe;

   uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (baud_clear),
      .run    (baud_run),
      .div    (div_q),
      .strobe (strobe)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tx_ready   = 1'b0;
      load_en    = 1'b0;
      tx_sel     = 1'b0;
      busy       = 1'b1;
      tx_done    = 1'b0;
      baud_run   = 1'b0;
      baud_clear = 1'b0;
      err_set    = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            if (tx_valid) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            load_en    = 1'b1;
            baud_clear = 1'b1;
            state_nxt  = ST_SHIFT;
         end
         ST_SHIFT: begin
            tx_sel   = 1'b1;
            baud_run = 1'b1;
            // A complete flag this early means the datapath and the strobe count disagree.
            if (data_transmitted) err_set = 1'b1;
            if (strobe && (strobe_cnt == last_idx)) state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            tx_sel = 1'b1;
            if (data_transmitted) begin
               state_nxt = ST_DONE;
            end else if (wait_cnt == WT_W'(DONE_TIMEOUT - 1)) begin
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            tx_done   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame parameters are captured at acceptance so later config writes cannot disturb the frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_byte  <= '0;
         stop_bit <= '0;
         div_q    <= '0;
      end else if (state == ST_IDLE && tx_valid) begin
         tx_byte  <= tx_data;
         stop_bit <= clamp_stop(cfg_stop);
         div_q    <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         strobe_cnt <= '0;
      end else if (state == ST_LOAD) begin
         strobe_cnt <= '0;
      end else if (state == ST_SHIFT && strobe) begin
         strobe_cnt <= strobe_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (state == ST_WAIT_DONE) begin
         wait_cnt <= wait_cnt + WT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (err_set) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: table-driven and random frames compared
// cycle by cycle against an arithmetic model of the frame timeline.
module tb_uart_tx_ctrl;

   localparam int DIV_W = 16;
   localparam int TO    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       tx_data;
   logic [1:0]       cfg_stop;
   logic [DIV_W-1:0] cfg_div;
   logic             data_transmitted;
   logic             load_en;
   logic             tx_enable;
   logic             tx_sel;
   logic [7:0]       tx_byte;
   logic [1:0]       stop_bit;
   logic             busy;
   logic             tx_done;
   logic             err;
   logic             err_clr;

   int   vectors     = 0;
   int   miscompares = 0;
   logic err_m       = 1'b0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(
      .DIV_W        (DIV_W),
      .DONE_TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .tx_data          (tx_data),
      .cfg_stop         (cfg_stop),
      .cfg_div          (cfg_div),
      .data_transmitted (data_transmitted),
      .load_en          (load_en),
      .tx_enable        (tx_enable),
      .tx_sel           (tx_sel),
      .tx_byte          (tx_byte),
      .stop_bit         (stop_bit),
      .busy             (busy),
      .tx_done          (tx_done),
      .err              (err),
      .err_clr          (err_clr)
   );

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  stop;
      logic [15:0] div;
      bit          respond;
      int          early;
      logic [1:0]  xs;
      int          xn;
      int          xd;
   } vec_t;

   vec_t tbl[6];

   // {load_en, tx_enable, tx_sel, tx_done, busy, tx_ready, err, tx_byte, stop_bit}
   function automatic logic [16:0] outs();
      return {load_en, tx_enable, tx_sel, tx_done, busy, tx_ready, err, tx_byte, stop_bit};
   endfunction

   task automatic check(input string name, input int cyc, input logic [16:0] got,
                        input logic [16:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %05h expected %05h", name, cyc, got, exp);
      end
   endtask

   // Offers one byte from IDLE and checks every cycle until the controller is idle again.
   // Cycle 1 is the LOAD cycle; strobes land at 1 + k*xd for k = 1..xn.
   task automatic frame(input logic [7:0] data, input logic [1:0] stop, input logic [15:0] div,
                        input bit respond, input int early, input logic [1:0] xs,
                        input int xn, input int xd);
      int          l;
      int          last;
      logic        e_load, e_en, e_sel, e_done, e_busy, e_rdy;
      @(negedge clk);
      check("idle_before", 0, outs() & 17'h1fc00, {6'b000001, err_m, 10'h0} & 17'h1fc00);
      tx_valid         = 1'b1;
      tx_data          = data;
      cfg_stop         = stop;
      cfg_div          = div;
      data_transmitted = 1'b0;
      err_clr          = 1'b0;
      l    = 1 + xn * xd;
      last = respond ? l + 3 : l + 1 + TO;
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (early != 0 && c == early + 1) err_m = 1'b1;
         if (!respond && c == last) err_m = 1'b1;
         e_load = (c == 1);
         e_en   = (c > 1) && (c <= l) && ((c - 1) % xd == 0);
         e_sel  = (c >= 2) && (c <= (respond ? l + 1 : l + TO));
         e_done = respond && (c == l + 2);
         e_busy = (c < last);
         e_rdy  = (c == last);
         check("frame", c, outs(), {e_load, e_en, e_sel, e_done, e_busy, e_rdy, err_m, data, xs});
         tx_valid         = (c == last) ? 1'b0 : 1'($urandom);
         tx_data          = 8'($urandom);
         cfg_stop         = 2'($urandom);
         cfg_div          = 16'($urandom_range(0, 20));
         data_transmitted = (respond && c == l + 1) || (early != 0 && c == early);
         err_clr          = (early != 0 && c == early);
      end
      tx_valid         = 1'b0;
      data_transmitted = 1'b0;
      err_clr          = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      err_m   = 1'b0;
      check("err_clr", 0, {16'h0, err}, 17'h0);
   endtask

   initial begin
      logic [7:0]  rd;
      logic [1:0]  rs;
      logic [15:0] rv;
      bit          rr;
      int          n;

      tbl[0] = '{8'hA5, 2'd0, 16'd4, 1'b1, 0, 2'd0, 10, 4};
      tbl[1] = '{8'h5A, 2'd3, 16'd1, 1'b1, 0, 2'd1, 11, 1};
      tbl[2] = '{8'hC3, 2'd0, 16'd0, 1'b1, 0, 2'd0, 10, 1};
      tbl[3] = '{8'h81, 2'd2, 16'd3, 1'b0, 0, 2'd1, 11, 3};
      tbl[4] = '{8'h7E, 2'd1, 16'd2, 1'b1, 6, 2'd1, 11, 2};
      tbl[5] = '{8'h0F, 2'd0, 16'd5, 1'b1, 9, 2'd0, 10, 5};

      reset            = 1'b0;
      tx_valid         = 1'b0;
      tx_data          = 8'h00;
      cfg_stop         = 2'd0;
      cfg_div          = '0;
      data_transmitted = 1'b0;
      err_clr          = 1'b0;
      repeat (2) @(negedge clk);
      check("reset", 0, outs(), {6'b000001, 1'b0, 8'h00, 2'd0});
      reset = 1'b1;

      for (int i = 0; i < 6; i++) begin
         frame(tbl[i].data, tbl[i].stop, tbl[i].div, tbl[i].respond, tbl[i].early,
               tbl[i].xs, tbl[i].xn, tbl[i].xd);
         if (i == 4) clear_err();
      end
      clear_err();

      // Reset asserted mid-SHIFT after five strobes, then a clean full frame.
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      cfg_stop = 2'd0;
      cfg_div  = 16'd2;
      n = 0;
      for (int c = 1; c <= 40 && n < 5; c++) begin
         @(negedge clk);
         tx_valid = 1'b0;
         if (tx_enable) n++;
      end
      check("reset_strobes", 0, 17'(n), 17'd5);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("reset_mid", 0, outs(), {6'b000001, 1'b0, 8'h00, 2'd0});
      err_m = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      frame(8'h96, 2'd0, 16'd3, 1'b1, 0, 2'd0, 10, 3);

      for (int i = 0; i < 12; i++) begin
         rd = 8'($urandom);
         rs = 2'($urandom);
         rv = 16'($urandom_range(0, 6));
         rr = ($urandom_range(0, 3) != 0);
         frame(rd, rs, rv, rr, 0, (rs != 2'd0) ? 2'd1 : 2'd0, (rs != 2'd0) ? 11 : 10,
               (rv < 16'd2) ? 1 : int'(rv));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
